// File: rtl/ecc_pkg.sv
// Curve, adder-latency and FSM definitions shared by the ECC decrypt datapath.
// Curve is y^2 = x^3 + CURVE_A*x + CURVE_B over GF(P); infinity is projective (0,1,0).
package ecc_pkg;
    localparam int P       = 7;
    localparam int CURVE_A = 0;
    localparam int CURVE_B = 3;
    localparam int ADD_LAT = 2;

    localparam int INF_X = 0;
    localparam int INF_Y = 1;
    localparam int INF_Z = 0;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        DBL,
        DBL_WAIT,
        ADD,
        ADD_WAIT,
        FINAL,
        FINAL_WAIT,
        DONE
    } state_t;
endpackage

// File: rtl/ecc_point_add.sv
// Projective point add/double: operands captured on i_start, o_done pulses ADD_LAT cycles later.
// No backpressure; the result register holds until the next i_start.
module ecc_point_add
    import ecc_pkg::*;
#(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_start,
    input  logic [N-1:0] i_ax,
    input  logic [N-1:0] i_ay,
    input  logic [N-1:0] i_az,
    input  logic [N-1:0] i_bx,
    input  logic [N-1:0] i_by,
    input  logic [N-1:0] i_bz,
    output logic         o_done,
    output logic [N-1:0] o_rx,
    output logic [N-1:0] o_ry,
    output logic [N-1:0] o_rz
);
    localparam int             CW  = $clog2(ADD_LAT + 1);
    localparam logic [N:0]     P1  = (N+1)'(P);
    localparam logic [2*N-1:0] P2  = (2*N)'(P);
    localparam logic [N-1:0]   PE  = N'(P - 2);
    localparam logic [N-1:0]   K2  = N'(2 % P);
    localparam logic [N-1:0]   K3  = N'(3 % P);
    localparam logic [N-1:0]   KA  = N'(CURVE_A % P);
    localparam logic [N-1:0]   ONE = N'(1);

    function automatic logic [N-1:0] f_add(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N:0] t;
        t = {1'b0, a} + {1'b0, b};
        if (t >= P1) t = t - P1;
        return t[N-1:0];
    endfunction

    function automatic logic [N-1:0] f_sub(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N:0] t;
        t = {1'b0, a} + P1 - {1'b0, b};
        if (t >= P1) t = t - P1;
        return t[N-1:0];
    endfunction

    function automatic logic [N-1:0] f_mul(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [2*N-1:0] t;
        t = {{N{1'b0}}, a} * {{N{1'b0}}, b};
        t = t % P2;
        return t[N-1:0];
    endfunction

    // Fermat inverse a^(P-2); the inverse of zero is never consumed.
    function automatic logic [N-1:0] f_inv(input logic [N-1:0] a);
        logic [N-1:0] r;
        logic [N-1:0] b;
        r = ONE;
        b = a;
        for (int k = 0; k < N; k++) begin
            if (PE[k]) r = f_mul(r, b);
            b = f_mul(b, b);
        end
        return r;
    endfunction

    logic [N-1:0] w_zia, w_zib, w_ax, w_ay, w_bx, w_by;
    logic [N-1:0] w_lam, w_x3, w_y3;
    logic [N-1:0] w_rx, w_ry, w_rz;
    logic         w_fin;

    always_comb begin
        w_zia = f_inv(i_az);
        w_zib = f_inv(i_bz);
        w_ax  = f_mul(i_ax, w_zia);
        w_ay  = f_mul(i_ay, w_zia);
        w_bx  = f_mul(i_bx, w_zib);
        w_by  = f_mul(i_by, w_zib);
        w_lam = '0;
        w_fin = 1'b0;
        w_rx  = N'(INF_X);
        w_ry  = N'(INF_Y);
        w_rz  = N'(INF_Z);
        if (i_az == '0) begin
            w_rx = i_bx;
            w_ry = i_by;
            w_rz = i_bz;
        end else if (i_bz == '0) begin
            w_rx = i_ax;
            w_ry = i_ay;
            w_rz = i_az;
        end else if (w_ax == w_bx) begin
            // Equal x: doubling when y matches and is nonzero, otherwise P == -Q gives infinity.
            if ((w_ay == w_by) && (w_ay != '0)) begin
                w_lam = f_mul(f_add(f_mul(K3, f_mul(w_ax, w_ax)), KA), f_inv(f_mul(K2, w_ay)));
                w_fin = 1'b1;
            end
        end else begin
            w_lam = f_mul(f_sub(w_by, w_ay), f_inv(f_sub(w_bx, w_ax)));
            w_fin = 1'b1;
        end
        w_x3 = f_sub(f_sub(f_mul(w_lam, w_lam), w_ax), w_bx);
        w_y3 = f_sub(f_mul(w_lam, f_sub(w_ax, w_x3)), w_ay);
        if (w_fin) begin
            w_rx = w_x3;
            w_ry = w_y3;
            w_rz = ONE;
        end
    end

    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_rx, r_ry, r_rz;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_rx  <= N'(INF_X);
            r_ry  <= N'(INF_Y);
            r_rz  <= N'(INF_Z);
        end else if (i_start) begin
            r_cnt <= CW'(ADD_LAT);
            r_rx  <= w_rx;
            r_ry  <= w_ry;
            r_rz  <= w_rz;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_done = (r_cnt == CW'(1));
    assign o_rx   = r_rx;
    assign o_ry   = r_ry;
    assign o_rz   = r_rz;
endmodule

// File: rtl/ecc_decrypt_engine.sv
// ElGamal-style ECC decrypt M = C2 - DS*C1 via MSB-first double-and-add on a shared point adder.
// Latency (KW+popcount(DS)+1)*(ADD_LAT+1)+1 from accept; result held in DONE until out_ready.
module ecc_decrypt_engine
    import ecc_pkg::*;
#(
    parameter int N  = 3,
    parameter int DS = 4,
    parameter int KW = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] c1_x,
    input  logic [N-1:0] c1_y,
    input  logic [N-1:0] c1_z,
    input  logic [N-1:0] c2_x,
    input  logic [N-1:0] c2_y,
    input  logic [N-1:0] c2_z,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] pt_x,
    output logic [N-1:0] pt_y,
    output logic [N-1:0] pt_z,
    output logic         busy
);
    localparam int            IW      = (KW > 1) ? $clog2(KW) : 1;
    localparam logic [KW-1:0] DS_BITS = KW'(DS);
    localparam logic [N-1:0]  P_N     = N'(P);

    state_t        r_state, w_next;
    logic [N-1:0]  r_c1x, r_c1y, r_c1z, r_c2x, r_c2y, r_c2z;
    logic [N-1:0]  r_rx, r_ry, r_rz;
    logic [N-1:0]  r_ptx, r_pty, r_ptz;
    logic [IW-1:0] r_idx;

    logic          w_start, w_done, w_step;
    logic [N-1:0]  w_ax, w_ay, w_az, w_bx, w_by, w_bz;
    logic [N-1:0]  w_sx, w_sy, w_sz;
    logic [N-1:0]  w_nry;

    assign w_nry = (r_ry == '0) ? '0 : P_N - r_ry;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_step  = 1'b0;
        w_ax    = r_rx;
        w_ay    = r_ry;
        w_az    = r_rz;
        w_bx    = r_rx;
        w_by    = r_ry;
        w_bz    = r_rz;
        case (r_state)
            IDLE:     if (in_valid) w_next = LOAD;
            LOAD:     w_next = DBL;
            DBL: begin
                w_start = 1'b1;
                w_next  = DBL_WAIT;
            end
            DBL_WAIT: if (w_done) begin
                if (DS_BITS[r_idx]) begin
                    w_next = ADD;
                end else if (r_idx == '0) begin
                    w_next = FINAL;
                end else begin
                    w_next = DBL;
                    w_step = 1'b1;
                end
            end
            ADD: begin
                w_start = 1'b1;
                w_bx    = r_c1x;
                w_by    = r_c1y;
                w_bz    = r_c1z;
                w_next  = ADD_WAIT;
            end
            ADD_WAIT: if (w_done) begin
                if (r_idx == '0) begin
                    w_next = FINAL;
                end else begin
                    w_next = DBL;
                    w_step = 1'b1;
                end
            end
            FINAL: begin
                // C2 + (-R): negation only touches y.
                w_start = 1'b1;
                w_ax    = r_c2x;
                w_ay    = r_c2y;
                w_az    = r_c2z;
                w_bx    = r_rx;
                w_by    = w_nry;
                w_bz    = r_rz;
                w_next  = FINAL_WAIT;
            end
            FINAL_WAIT: if (w_done) w_next = DONE;
            DONE:       if (out_ready) w_next = IDLE;
            default:    w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_c1x <= '0;
            r_c1y <= '0;
            r_c1z <= '0;
            r_c2x <= '0;
            r_c2y <= '0;
            r_c2z <= '0;
            r_rx  <= N'(INF_X);
            r_ry  <= N'(INF_Y);
            r_rz  <= N'(INF_Z);
            r_ptx <= '0;
            r_pty <= '0;
            r_ptz <= '0;
            r_idx <= '0;
        end else begin
            if (r_state == IDLE && in_valid) begin
                r_c1x <= c1_x;
                r_c1y <= c1_y;
                r_c1z <= c1_z;
                r_c2x <= c2_x;
                r_c2y <= c2_y;
                r_c2z <= c2_z;
            end
            case (r_state)
                LOAD: begin
                    r_rx  <= N'(INF_X);
                    r_ry  <= N'(INF_Y);
                    r_rz  <= N'(INF_Z);
                    r_idx <= IW'(KW - 1);
                end
                DBL_WAIT, ADD_WAIT: if (w_done) begin
                    r_rx <= w_sx;
                    r_ry <= w_sy;
                    r_rz <= w_sz;
                end
                FINAL_WAIT: if (w_done) begin
                    r_ptx <= w_sx;
                    r_pty <= w_sy;
                    r_ptz <= w_sz;
                end
                default: ;
            endcase
            if (w_step) r_idx <= r_idx - IW'(1);
        end
    end

    ecc_point_add #(.N(N)) u_add (
        .clk     (clk),
        .reset   (reset),
        .i_start (w_start),
        .i_ax    (w_ax),
        .i_ay    (w_ay),
        .i_az    (w_az),
        .i_bx    (w_bx),
        .i_by    (w_by),
        .i_bz    (w_bz),
        .o_done  (w_done),
        .o_rx    (w_sx),
        .o_ry    (w_sy),
        .o_rz    (w_sz)
    );

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = (r_state == DONE);
    assign pt_x      = r_ptx;
    assign pt_y      = r_pty;
    assign pt_z      = r_ptz;
endmodule

// File: doc/ecc_decrypt_engine.md
ECC_DECRYPT_ENGINE -- requirements
Module: ecc_decrypt_engine

Interface
REQ-001 SHALL have parameter N, default 3: coordinate width in bits.
REQ-002 SHALL have parameter DS, default 4: private scalar.
REQ-003 SHALL have parameter KW, default 3: scalar bit count processed.
REQ-004 SHALL have ports: clk in 1 clock; reset in 1, asynchronous, active-high; in_valid in 1; in_ready out 1.
REQ-005 SHALL have ports: c1_x/c1_y/c1_z in N each, ciphertext point C1 (projective); c2_x/c2_y/c2_z in N each, ciphertext point C2.
REQ-006 SHALL have ports: out_valid out 1; out_ready in 1; pt_x/pt_y/pt_z out N each, recovered plaintext point M; busy out 1.

Function
REQ-007 SHALL compute M = C2 - DS*C1 over curve y^2 = x^3 + CURVE_B mod P (package defaults P=7, CURVE_A=0, CURVE_B=3), projective coordinates, infinity = (0,1,0).
REQ-008 SHALL assert in_ready only in IDLE; accept on in_valid && in_ready, latching all six inputs.
REQ-009 SHALL use FSM states IDLE, LOAD, DBL, DBL_WAIT, ADD, ADD_WAIT, FINAL, FINAL_WAIT, DONE.
REQ-010 LOAD SHALL set accumulator R = infinity and bit index i = KW-1.
REQ-011 For each i from KW-1 down to 0: DBL/DBL_WAIT SHALL compute R = 2R; if DS[i]=1, ADD/ADD_WAIT SHALL compute R = R + C1; else skip to next i.
REQ-012 After i=0, FINAL SHALL form -R = (Rx, (P - Ry) mod P, Rz) combinationally and issue C2 + (-R).
REQ-013 Each *_WAIT state SHALL hold until adder done; DBL/ADD/FINAL SHALL be exactly one cycle, pulsing adder start.
REQ-014 Latency: out_valid SHALL rise exactly (KW + popcount(DS) + 1)*(L+1) + 1 cycles after accept edge, L = fixed adder latency.
REQ-015 DONE SHALL assert out_valid with pt_* stable; exit to IDLE on out_valid && out_ready; hold indefinitely otherwise.
REQ-016 busy SHALL be 1 in every state except IDLE.
REQ-017 Output is projective, not normalized; correctness is projective equivalence (x*z' == x'*z, y*z' == y'*z mod P).
REQ-018 DS=0: SHALL still run KW doublings of infinity; result equals C2.
REQ-019 C1 with z=0 (infinity): result equals C2.
REQ-020 C2 == DS*C1: result SHALL be infinity (pt_z = 0).
REQ-021 in_valid during busy SHALL be ignored; inputs not latched.
REQ-022 Inputs SHALL be assumed reduced (< P) and on-curve; no checking.

Reset
REQ-023 reset SHALL force IDLE asynchronously, discarding any operation in progress.
REQ-024 On reset: in_ready=1 after release, out_valid=0, busy=0, pt_*=0, R=infinity, i=0, adder start=0.
REQ-025 Adder sub-module SHALL share clk/reset; done pulses from a discarded operation SHALL be ignored in IDLE.

Structure
REQ-026 Package ecc_pkg SHALL hold P, CURVE_A, CURVE_B, adder latency L, FSM state encoding, infinity-point constants.
REQ-027 Group law (add/double, infinity and P==Q/P==-Q cases, mod-P arithmetic) SHALL live in one sub-module ecc_point_add (start, done, two projective operands, projective result, fixed latency L).
REQ-028 ecc_decrypt_engine SHALL contain only control, accumulator, negation and handshake logic.

Verification
REQ-029 DS=4, C1=(1,2,1), C2=(3,3,1), out_ready=1 -> pt equivalent to (1,2,1); latency per REQ-014 (KW=3, popcount=1).
REQ-030 DS=4, C1=(1,2,1), C2=(4,5,1) -> pt_z=0 (infinity).
REQ-031 C1=(0,1,0), C2=(6,3,1), any DS -> pt equivalent to (6,3,1).
REQ-032 out_ready=0 for 10 cycles in DONE -> out_valid and pt_* held constant; in_ready=0; then out_ready=1 -> IDLE next cycle.
REQ-033 reset asserted in ADD_WAIT -> outputs immediately at reset values; next transaction (REQ-029 values) completes correctly.
REQ-034 in_valid pulsed with different data while busy -> result unchanged from first accepted transaction.
